clk_div_gen: RTL

//   Parametrised, run-time programmable clock divider and clock-enable generator.

---
 rtl/clk_div_gen.sv | 81 ++++++++
 1 files changed

// File: rtl/clk_div_gen.sv
// Programmable clock divider with rise/fall clock-enable strobes; all outputs registered (1-cycle latency).
// No backpressure: div_load is always accepted (last wins). Optional DIV_PERIOD_CNT_EN adds period_cnt.
module clk_div_gen #(
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             busy,
   output logic             clk_out,
   output logic             tick_rise,
   output logic             tick_fall
`ifdef DIV_PERIOD_CNT_EN
   ,
   output logic [15:0]      period_cnt
`endif
);
   localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0] cnt, div_n, pend, load_n;
   logic [CNT_W-1:0] cnt_nxt, n_nxt, low_nxt;
   logic             wrap;

   // Divisors below 2 cannot produce both phases, so they are clamped up.
   assign load_n = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
   assign wrap   = (cnt >= div_n - CNT_W'(1));

   always_comb begin
      cnt_nxt = cnt + CNT_W'(1);
      n_nxt   = div_n;
      if (wrap) begin
         cnt_nxt = '0;
         if (busy) n_nxt = pend;
      end
   end

   assign low_nxt = n_nxt - (n_nxt >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         div_n     <= DEF_N;
         pend      <= DEF_N;
         busy      <= 1'b0;
         div_ack   <= 1'b0;
         clk_out   <= 1'b0;
         tick_rise <= 1'b0;
         tick_fall <= 1'b0;
      end else begin
         div_ack <= div_load;
         if (div_load) pend <= load_n;
         if (en) begin
            cnt       <= cnt_nxt;
            div_n     <= n_nxt;
            clk_out   <= (cnt_nxt >= low_nxt);
            tick_rise <= (cnt_nxt == low_nxt);
            tick_fall <= wrap;
            // A load at the applying wrap keeps busy set for the new value.
            busy      <= div_load | (busy & ~wrap);
         end else begin
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            if (div_load) busy <= 1'b1;
         end
      end
   end

`ifdef DIV_PERIOD_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         period_cnt <= 16'd0;
      else if (en && wrap)
         period_cnt <= period_cnt + 16'd1;
   end
`endif

endmodule
